// File: rtl/rename_if.sv
`default_nettype none
// ============================================================================
// Module   : rename_if
// Brief    : Request, downstream, commit-return and status signals of the
//            register rename stage.
// Revision : 1.0
// ============================================================================
interface rename_if #(
    parameter int NUM_AREGS = 32,
    parameter int NUM_PREGS = 64
);
    localparam int AW = $clog2(NUM_AREGS);
    localparam int PW = $clog2(NUM_PREGS);

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic [AW-1:0] in_rd;
    logic          in_wen;
    logic [31:0]   in_instr;

    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_ps1;
    logic [PW-1:0] out_ps2;
    logic [PW-1:0] out_pd;
    logic [PW-1:0] out_old_pd;
    logic [31:0]   out_instr;

    logic          ret_valid;
    logic [PW-1:0] ret_preg;

    logic [PW:0]   free_count;
    logic          overflow_err;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_wen, in_instr,
        input  out_ready, ret_valid, ret_preg,
        output in_ready, out_valid, out_ps1, out_ps2, out_pd, out_old_pd,
        output out_instr, free_count, overflow_err
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_wen, in_instr,
        output out_ready, ret_valid, ret_preg,
        input  in_ready, out_valid, out_ps1, out_ps2, out_pd, out_old_pd,
        input  out_instr, free_count, overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/rename_stage.sv
`default_nettype none
// ============================================================================
// Module   : rename_stage
// Brief    : Single-cycle register renamer: RAT lookup, free-list allocation
//            and commit-time physical register return.
// Revision : 1.0
// ============================================================================
module rename_stage #(
    parameter int NUM_AREGS = 32,
    parameter int NUM_PREGS = 64
) (
    input  wire logic clk,
    input  wire logic rst,
    rename_if.slave   bus
);
    localparam int AW       = $clog2(NUM_AREGS);
    localparam int PW       = $clog2(NUM_PREGS);
    localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int FLW      = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

    localparam logic [PW:0]    C_FL_DEPTH = (PW+1)'(FL_DEPTH);
    localparam logic [FLW-1:0] C_FL_LAST  = FLW'(FL_DEPTH - 1);

    logic [PW-1:0]  rat_q [NUM_AREGS];
    logic [PW-1:0]  fl_q  [FL_DEPTH];
    logic [FLW-1:0] head_q, head_d;
    logic [FLW-1:0] tail_q, tail_d;
    logic [PW:0]    count_q, count_d;
    logic           ovf_q, ovf_d;

    logic           out_valid_q;
    logic [PW-1:0]  out_ps1_q, out_ps2_q, out_pd_q, out_old_pd_q;
    logic [31:0]    out_instr_q;

    logic w_alloc, w_ready, w_accept, w_pop, w_push_req, w_full, w_push;

    always_comb begin
        w_alloc    = bus.in_wen && (bus.in_rd != '0);
        // Registered count only: a register returned this cycle is not yet allocatable.
        w_ready    = (!out_valid_q || bus.out_ready) && (!w_alloc || count_q != '0);
        w_accept   = bus.in_valid && w_ready;
        w_pop      = w_accept && w_alloc;
        w_push_req = bus.ret_valid && (bus.ret_preg != '0);
        w_full     = (count_q == C_FL_DEPTH);
        w_push     = w_push_req && (!w_full || w_pop);
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (w_pop) begin
            head_d = (head_q == C_FL_LAST) ? '0 : head_q + FLW'(1);
        end
        if (w_push) begin
            tail_d = (tail_q == C_FL_LAST) ? '0 : tail_q + FLW'(1);
        end
        count_d = count_q + (PW+1)'(w_push) - (PW+1)'(w_pop);
        if (w_push_req && !w_push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                rat_q[i] <= PW'(i);
            end
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= PW'(NUM_AREGS + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= C_FL_DEPTH;
            ovf_q   <= 1'b0;
        end else begin
            if (w_pop) begin
                rat_q[bus.in_rd] <= fl_q[head_q];
            end
            if (w_push) begin
                fl_q[tail_q] <= bus.ret_preg;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Sources and old_pd read the RAT before this cycle's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_ps1_q    <= '0;
            out_ps2_q    <= '0;
            out_pd_q     <= '0;
            out_old_pd_q <= '0;
            out_instr_q  <= '0;
        end else if (w_accept) begin
            out_valid_q  <= 1'b1;
            out_ps1_q    <= rat_q[bus.in_rs1];
            out_ps2_q    <= rat_q[bus.in_rs2];
            out_pd_q     <= w_alloc ? fl_q[head_q] : '0;
            out_old_pd_q <= w_alloc ? rat_q[bus.in_rd] : '0;
            out_instr_q  <= bus.in_instr;
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_ps1      = out_ps1_q;
    assign bus.out_ps2      = out_ps2_q;
    assign bus.out_pd       = out_pd_q;
    assign bus.out_old_pd   = out_old_pd_q;
    assign bus.out_instr    = out_instr_q;
    assign bus.free_count   = count_q;
    assign bus.overflow_err = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_rename_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename_stage
// Brief    : Directed vector table plus hand-written corner sequences for
//            rename_stage (32 architectural / 64 physical registers).
// Revision : 1.0
// ============================================================================
module tb_rename_stage;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    int   xfers;

    rename_if #(.NUM_AREGS(32), .NUM_PREGS(64)) bus ();

    rename_stage #(.NUM_AREGS(32), .NUM_PREGS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) xfers++;
    end

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       wen;
        logic [5:0] ps1, ps2, pd, opd;
        logic [6:0] fc;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen, input logic [31:0] instr);
        bus.in_valid = v;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_rd    = rd;
        bus.in_wen   = wen;
        bus.in_instr = instr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int base;
        n_vec = 0;
        n_bad = 0;
        xfers = 0;
        tbl[0] = '{5'd1, 5'd2, 5'd5, 1'b1, 6'd1,  6'd2,  6'd32, 6'd5,  7'd31};
        tbl[1] = '{5'd5, 5'd0, 5'd5, 1'b1, 6'd32, 6'd0,  6'd33, 6'd32, 7'd30};
        tbl[2] = '{5'd5, 5'd3, 5'd0, 1'b1, 6'd33, 6'd3,  6'd0,  6'd0,  7'd30};
        tbl[3] = '{5'd0, 5'd5, 5'd7, 1'b0, 6'd0,  6'd33, 6'd0,  6'd0,  7'd30};
        tbl[4] = '{5'd7, 5'd5, 5'd7, 1'b1, 6'd7,  6'd33, 6'd34, 6'd7,  7'd29};
        tbl[5] = '{5'd7, 5'd0, 5'd1, 1'b1, 6'd34, 6'd0,  6'd35, 6'd1,  7'd28};

        drive(1'b0, '0, '0, '0, 1'b0, '0);
        bus.out_ready = 1'b1;
        bus.ret_valid = 1'b0;
        bus.ret_preg  = '0;
        do_reset();

        // Reset state
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_free_count", 64'(bus.free_count), 64'd32);
        chk("rst_overflow", 64'(bus.overflow_err), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_pd", 64'(bus.out_pd), 64'd0);

        // Vector table, one accept per cycle
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wen, 32'hA000_0000 + i);
            tick();
            chk($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("v%0d_ps1", i), 64'(bus.out_ps1), 64'(tbl[i].ps1));
            chk($sformatf("v%0d_ps2", i), 64'(bus.out_ps2), 64'(tbl[i].ps2));
            chk($sformatf("v%0d_pd", i), 64'(bus.out_pd), 64'(tbl[i].pd));
            chk($sformatf("v%0d_old_pd", i), 64'(bus.out_old_pd), 64'(tbl[i].opd));
            chk($sformatf("v%0d_free", i), 64'(bus.free_count), 64'(tbl[i].fc));
            chk($sformatf("v%0d_instr", i), 64'(bus.out_instr), 64'(32'hA000_0000 + i));
        end
        drive(1'b0, '0, '0, '0, 1'b0, '0);
        tick();
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);

        // Exhaust the free list, then return one register
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'((i % 31) + 1), 1'b1, 32'(i));
            tick();
        end
        chk("exh_free_count", 64'(bus.free_count), 64'd0);
        chk("exh_last_pd", 64'(bus.out_pd), 64'd63);
        drive(1'b0, 5'd0, 5'd0, 5'd3, 1'b1, '0);
        #1;
        chk("exh_ready_wen1", 64'(bus.in_ready), 64'd0);
        bus.in_wen = 1'b0;
        #1;
        chk("exh_ready_wen0", 64'(bus.in_ready), 64'd1);
        bus.in_wen    = 1'b1;
        bus.ret_valid = 1'b1;
        bus.ret_preg  = 6'd5;
        #1;
        chk("ret_same_cycle_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("ret_free_count", 64'(bus.free_count), 64'd1);
        bus.ret_preg = 6'd6;
        drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 32'h1234_5678);
        tick();
        chk("ret_pd", 64'(bus.out_pd), 64'd5);
        chk("ret_old_pd", 64'(bus.out_old_pd), 64'd40);
        chk("ret_ps1", 64'(bus.out_ps1), 64'd40);
        chk("popush_free_count", 64'(bus.free_count), 64'd1);
        bus.ret_valid = 1'b0;
        drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, '0);
        tick();
        chk("popush_pd", 64'(bus.out_pd), 64'd6);
        chk("popush_old_pd", 64'(bus.out_old_pd), 64'd41);
        chk("popush_free_after", 64'(bus.free_count), 64'd0);
        drive(1'b0, '0, '0, '0, 1'b0, '0);
        tick();

        // Downstream stall
        do_reset();
        bus.out_ready = 1'b0;
        base = xfers;
        drive(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 32'hBEEF_0001);
        tick();
        chk("stall_pd0", 64'(bus.out_pd), 64'd32);
        drive(1'b1, 5'd4, 5'd0, 5'd6, 1'b1, 32'hBEEF_0002);
        #1;
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_pd_frozen", 64'(bus.out_pd), 64'd32);
        chk("stall_instr_frozen", 64'(bus.out_instr), 64'hBEEF_0001);
        chk("stall_free", 64'(bus.free_count), 64'd31);
        bus.out_ready = 1'b1;
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, '0);
        chk("rel_ps1", 64'(bus.out_ps1), 64'd32);
        chk("rel_pd", 64'(bus.out_pd), 64'd33);
        chk("rel_old_pd", 64'(bus.out_old_pd), 64'd6);
        tick();
        tick();
        chk("rel_xfers", 64'(xfers - base), 64'd2);
        chk("rel_idle_valid", 64'(bus.out_valid), 64'd0);

        // Overflow on a full free list, then reset mid-stream
        do_reset();
        bus.ret_valid = 1'b1;
        bus.ret_preg  = 6'd40;
        tick();
        bus.ret_valid = 1'b0;
        chk("ovf_flag", 64'(bus.overflow_err), 64'd1);
        chk("ovf_count", 64'(bus.free_count), 64'd32);
        tick();
        chk("ovf_sticky", 64'(bus.overflow_err), 64'd1);
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_free", 64'(bus.free_count), 64'd32);
        chk("mrst_ovf", 64'(bus.overflow_err), 64'd0);
        rst = 1'b0;
        drive(1'b1, 5'd5, 5'd4, 5'd5, 1'b1, 32'h0);
        tick();
        chk("mrst_ps1", 64'(bus.out_ps1), 64'd5);
        chk("mrst_ps2", 64'(bus.out_ps2), 64'd4);
        chk("mrst_pd", 64'(bus.out_pd), 64'd32);
        chk("mrst_old_pd", 64'(bus.out_old_pd), 64'd5);
        drive(1'b0, '0, '0, '0, 1'b0, '0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
